tx2_stream: RTL

Buffered 32-bit stream transmitter that drives the valid/ready word interface consumed by the team's stream receivers. Upstream logic pushes words into a small internal FIFO with a fire-and-forget write strobe. The block presents one word at a time on `data`/`valid`, holds it stable until the receiver accepts it with `ready`, and keeps transfer and error status for debug display.

---
 rtl/tx2_stream.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tx2_stream.sv
// Buffered 32-bit stream transmitter: upstream write strobe into a small FIFO,
// one word offered at a time on a valid/ready interface, with debug status.
module tx2_stream #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STALL_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        valid,
  output logic [31:0] data,
  input  logic        ready,
  output logic        busy,
  output logic [15:0] sent_cnt,
  output logic        overflow,
  output logic        stall_err,
  input  logic        clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STALL_MAX + 2);

  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_ARM = SW'(STALL_MAX);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [31:0]   mem_q [DEPTH];
  logic [0:0]    state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  logic [15:0]   sent_cnt_q, sent_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          overflow_q, overflow_d;
  logic          stall_err_q, stall_err_d;

  logic fifo_empty, xfer, pop, bypass, push, drop, stalled, stall_evt;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pop        = 1'b0;
    bypass     = 1'b0;
    fifo_empty = (count_q == '0);
    xfer       = (state_q == SEND) && ready;
    stalled    = (state_q == SEND) && !ready;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end else if (wr_en) begin
          bypass  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else if (wr_en) begin
            bypass = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      data_d = mem_q[rd_ptr_q];
    end
    if (bypass) begin
      data_d = wr_data;
    end

    // Drop decision uses the registered full flag even if a pop frees a slot now
    drop = wr_en && full_q;
    push = wr_en && !full_q && !bypass;

    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end

    full_d     = (count_d == DEPTH_C);
    busy_d     = (state_d == SEND) || (count_d != '0);
    sent_cnt_d = xfer ? sent_cnt_q + 16'd1 : sent_cnt_q;

    stall_d = '0;
    if (stalled) begin
      stall_d = (stall_q == STALL_LIM) ? stall_q : stall_q + SW'(1);
    end
    // Only the transition into saturation is an event, so clr_err can clear a long stall
    stall_evt = stalled && (stall_q == STALL_ARM);

    overflow_d  = drop || (overflow_q && !clr_err);
    stall_err_d = stall_evt || (stall_err_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      sent_cnt_q  <= '0;
      stall_q     <= '0;
      overflow_q  <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      busy_q      <= busy_d;
      sent_cnt_q  <= sent_cnt_d;
      stall_q     <= stall_d;
      overflow_q  <= overflow_d;
      stall_err_q <= stall_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign valid     = (state_q == SEND);
  assign data      = data_q;
  assign full      = full_q;
  assign busy      = busy_q;
  assign sent_cnt  = sent_cnt_q;
  assign overflow  = overflow_q;
  assign stall_err = stall_err_q;

endmodule
